e203_exu_flush_arb: RTL
=======================

// Module: e203_exu_flush_arb
// PURPOSE
//  Parametrised N-source pipeline-flush arbiter for the EXU commit stage. It replaces the fixed two-way
//  excp/branch flush mux with a locked, priority-arbitrated request to the IFU flush port.
//  Keeps the granted flush-PC adder operands stable until pipe_flush_ack.
//  Counts completed flushes per source for debug/perf readout.
// PARAMETERS
//  NSRC   4   number of flush sources; index 0 = highest priority (exception/irq)
//  PC_W   32  flush adder operand width (E203_PC_SIZE)
//  CNT_W  16  per-source saturating flush counter width
// PORTS
//  clk                 in   1          core clock
//  rst_n               in   1          reset, synchronous, active-low
//  src_flush_req       in   NSRC       per-source flush request, held until its ack
//  src_flush_add_op1   in   NSRC*PC_W  per-source adder op1, slice i = [i*PC_W +: PC_W]
//  src_flush_add_op2   in   NSRC*PC_W  per-source adder op2
//  src_flush_ack       out  NSRC       per-source ack, one-hot0
//  pipe_flush_req      out  1          flush request to IFU
//  pipe_flush_add_op1  out  PC_W       granted op1
//  pipe_flush_add_op2  out  PC_W       granted op2
//  pipe_flush_ack      in   1          IFU accepts the flush
//  flush_pulse         out  1          pipe_flush_req & pipe_flush_ack
//  flush_src           out  NSRC       one-hot current grant; 0 when no request
//  flush_busy          out  1          1 in HOLD state
//  cnt_clr             in   1          clear all counters
//  cnt_sel             in   $clog2(NSRC)  counter readout select
//  cnt_val             out  CNT_W      counter[cnt_sel]; 0 if cnt_sel>=NSRC
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, gnt_r=0, all counters=0. While rst_n=0,
//    pipe_flush_req, src_flush_ack, flush_pulse and flush_src are forced to 0.
//  - IDLE: grant = lowest-index asserted src_flush_req (combinational, 0-cycle latency).
//    pipe_flush_req = |src_flush_req.
//    * ack in the same cycle: flush_pulse=1, stay in IDLE.
//    * no ack: latch the grant index into gnt_r and go to HOLD.
//  - HOLD: grant = gnt_r. pipe_flush_req = src_flush_req[gnt_r]. Operands come from source gnt_r.
//    Newly arriving higher-priority requests wait.
//    * ack: flush_pulse=1, go to IDLE. Re-arbitration happens in the next cycle.
//    * granted source withdraws its req (protocol violation, tolerated): pipe_flush_req=0 that cycle,
//      go to IDLE, no count.
//  - src_flush_ack[i] = flush_pulse & grant[i]. Ops are don't-care when pipe_flush_req=0; drive 0.
//  - Counters: counter[grant] += 1 on flush_pulse and saturates at 2^CNT_W-1.
//    cnt_clr has priority over a simultaneous increment (result 0). cnt_val is combinational.
//  - Back-to-back: a pulse in cycle n can be followed by a new grant pulse in cycle n+1. No bubble in IDLE.
// CONFIGURATION
//  E203_FLUSH_ARB_PREEMPT_EN
//  - Defined: in HOLD with gnt_r!=0, an asserted src_flush_req[0] preempts the held grant.
//    The grant switches to 0 in the same cycle and gnt_r<=0; operands change.
//    The preempted source is not acked or counted and stays pending for later re-arbitration.
//  - Undefined: strict lock, no preemption; operands are stable from first request to ack.
// STRUCTURE
//  - e203_defines.v: E203_FLUSH_SRC_EXCP=0, E203_FLUSH_SRC_BRCH=1 and the default NSRC/CNT_W.
//  - Sub-module e203_exu_flush_prio: parametrised lowest-index-wins priority encoder.
//    Outputs a one-hot vector and a binary index.
//  - Top level holds the 2-state FSM (IDLE/HOLD), gnt_r, operand muxes and the counter array.
//  - SVA (non-FPGA builds): onehot0(src_flush_ack), onehot0(flush_src), and
//    flush_busy -> $stable(pipe_flush_add_op1/op2) unless PREEMPT_EN fires.
// TESTING
//  1. req=4'b0110, ack=1 same cycle -> src_flush_ack=4'b0010, flush_pulse=1, cnt[1]=1, state IDLE.
//  2. req[2]=1 with ack low 3 cycles; req[0] rises in cycle 2; ack in cycle 4
//     -> ack[2] in cycle 4, ops stay = src2 throughout.
//     Next cycle: grant=0, ack[0] when acked. (PREEMPT_EN: grant switches to 0 in cycle 2, cnt[2] unchanged.)
//  3. CNT_W=4, 17 acked flushes from src 3 -> cnt_val(sel=3)=4'hF;
//     cnt_clr together with a pulse -> cnt=0.
//  4. HOLD on src 1, src 1 drops req before ack -> pipe_flush_req=0 that cycle, IDLE, cnt[1] unchanged.
//  5. rst_n=0 for 1 cycle during HOLD with all reqs high -> outputs 0 in that cycle.
//     Next cycle IDLE: grant=0, counters all 0.
//  6. NSRC=2, PC_W=32: random req/ack for 10k cycles -> no onehot0 violation.
//     Pulse count equals the sum of counters.

Source files
------------

// File: rtl/e203_exu_flush_arb_pkg.sv
// Shared types and constants for the EXU flush arbiter.
package e203_exu_flush_arb_pkg;

    localparam int E203_FLUSH_SRC_EXCP = 0;
    localparam int E203_FLUSH_SRC_BRCH = 1;

    localparam int FLUSH_ARB_NSRC  = 4;
    localparam int FLUSH_ARB_PC_W  = 32;
    localparam int FLUSH_ARB_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } flush_state_t;

    // Index width that stays legal for a single source.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/e203_exu_flush_prio.sv
// Lowest-index-wins priority encoder: one-hot grant plus binary index.
module e203_exu_flush_prio
    import e203_exu_flush_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/e203_exu_flush_arb.sv
// N-source locked flush arbiter with per-source saturating flush counters.
// Optional macro E203_FLUSH_ARB_PREEMPT_EN lets source 0 preempt a held grant.
module e203_exu_flush_arb
    import e203_exu_flush_arb_pkg::*;
#(
    parameter int NSRC  = FLUSH_ARB_NSRC,
    parameter int PC_W  = FLUSH_ARB_PC_W,
    parameter int CNT_W = FLUSH_ARB_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSRC-1:0]         src_flush_req,
    input  logic [NSRC*PC_W-1:0]    src_flush_add_op1,
    input  logic [NSRC*PC_W-1:0]    src_flush_add_op2,
    output logic [NSRC-1:0]         src_flush_ack,
    output logic                    pipe_flush_req,
    output logic [PC_W-1:0]         pipe_flush_add_op1,
    output logic [PC_W-1:0]         pipe_flush_add_op2,
    input  logic                    pipe_flush_ack,
    output logic                    flush_pulse,
    output logic [NSRC-1:0]         flush_src,
    output logic                    flush_busy,
    input  logic                    cnt_clr,
    input  logic [idx_w(NSRC)-1:0]  cnt_sel,
    output logic [CNT_W-1:0]        cnt_val
);

    localparam int IDX_W = idx_w(NSRC);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    flush_state_t     state, state_nxt;
    logic [IDX_W-1:0] gnt_r, gnt_nxt;
    logic [IDX_W-1:0] sel_idx;
    logic [NSRC-1:0]  prio_onehot, grant_vec;
    logic [IDX_W-1:0] prio_idx;
    logic             prio_any;
    logic             req_sel;
    logic             preempt;
    logic [CNT_W-1:0] cnt [NSRC];

    e203_exu_flush_prio #(.N(NSRC), .IDX_W(IDX_W)) u_prio (
        .req    (src_flush_req),
        .onehot (prio_onehot),
        .idx    (prio_idx),
        .any    (prio_any)
    );

`ifdef E203_FLUSH_ARB_PREEMPT_EN
    assign preempt = (state == ST_HOLD) && src_flush_req[E203_FLUSH_SRC_EXCP] && (gnt_r != '0);
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        sel_idx   = '0;
        grant_vec = '0;
        req_sel   = 1'b0;
        if (state == ST_IDLE) begin
            sel_idx   = prio_idx;
            grant_vec = prio_onehot;
            req_sel   = prio_any;
        end else begin
            sel_idx = preempt ? IDX_W'(E203_FLUSH_SRC_EXCP) : gnt_r;
            for (int i = 0; i < NSRC; i++) grant_vec[i] = (sel_idx == IDX_W'(i));
            req_sel = src_flush_req[sel_idx];
        end
    end

    // Reset is sampled synchronously, so the handshake outputs are gated combinationally.
    assign pipe_flush_req = rst_n & req_sel;
    assign flush_src      = pipe_flush_req ? grant_vec : '0;
    assign flush_pulse    = pipe_flush_req & pipe_flush_ack;
    assign src_flush_ack  = flush_pulse ? flush_src : '0;
    assign flush_busy     = (state == ST_HOLD);

    always_comb begin
        pipe_flush_add_op1 = '0;
        pipe_flush_add_op2 = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (flush_src[i]) begin
                pipe_flush_add_op1 = src_flush_add_op1[i*PC_W +: PC_W];
                pipe_flush_add_op2 = src_flush_add_op2[i*PC_W +: PC_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_r;
        if (state == ST_IDLE) begin
            if (prio_any && !pipe_flush_ack) begin
                state_nxt = ST_HOLD;
                gnt_nxt   = prio_idx;
            end
        end else begin
            if (preempt) gnt_nxt = IDX_W'(E203_FLUSH_SRC_EXCP);
            // An ack or a withdrawn request both release the lock.
            if (flush_pulse || !req_sel) state_nxt = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt_r <= '0;
        end else begin
            state <= state_nxt;
            gnt_r <= gnt_nxt;
        end
    end

    // NOTE: the counter array is reset explicitly because software reads it straight after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) cnt[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NSRC; i++) cnt[i] <= '0;
        end else if (flush_pulse) begin
            for (int i = 0; i < NSRC; i++) begin
                if (flush_src[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign cnt_val = (int'(cnt_sel) < NSRC) ? cnt[cnt_sel] : '0;

`ifndef FPGA_SOURCE
    a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(src_flush_ack));
    a_src_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(flush_src));
    a_ops_stable:  assert property (@(posedge clk) disable iff (!rst_n)
        (flush_busy && pipe_flush_req && !preempt && $past(flush_busy && pipe_flush_req))
        |-> ($stable(pipe_flush_add_op1) && $stable(pipe_flush_add_op2)));
`endif

endmodule
